// File: rtl/registerset_param.sv
// Parameterised register file: one write port (load/inc/dec/clear) and two registered read ports.
// Optional macro REGSET_BYPASS_EN: a read of a register written at the same edge returns the new value.
module registerset_param #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned SEL_WIDTH     = 2,
   parameter int unsigned NUM_REGISTERS = 4
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  wr_en,
   input  logic [1:0]            wr_op,
   input  logic [SEL_WIDTH-1:0]  wr_sel,
   input  logic [DATA_WIDTH-1:0] reg_in,
   input  logic                  rd_en1,
   input  logic                  rd_en2,
   input  logic [SEL_WIDTH-1:0]  rd_sel1,
   input  logic [SEL_WIDTH-1:0]  rd_sel2,
   output logic [DATA_WIDTH-1:0] reg_out_1,
   output logic [DATA_WIDTH-1:0] reg_out_2,
   output logic                  wr_wrap
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_INC   = 2'b01;
   localparam logic [1:0] OP_DEC   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic [DATA_WIDTH-1:0] regs       [NUM_REGISTERS];
   logic [DATA_WIDTH-1:0] regs_nxt_c [NUM_REGISTERS];
   logic [DATA_WIDTH-1:0] rd_view_c  [NUM_REGISTERS];
   logic [DATA_WIDTH-1:0] old_c;
   logic [DATA_WIDTH-1:0] new_c;
   logic [DATA_WIDTH-1:0] rd_data1_c;
   logic [DATA_WIDTH-1:0] rd_data2_c;
   logic                  wr_hit_c;
   logic                  wrap_c;

   // Write target lookup; selects beyond the implemented range never hit.
   always_comb begin
      wr_hit_c = 1'b0;
      old_c    = '0;
      for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
         if (wr_en && (wr_sel == SEL_WIDTH'(i))) begin
            wr_hit_c = 1'b1;
            old_c    = regs[i];
         end
      end
   end

   always_comb begin
      new_c = old_c;
      case (wr_op)
         OP_LOAD:  new_c = reg_in;
         OP_INC:   new_c = old_c + DATA_WIDTH'(1);
         OP_DEC:   new_c = old_c - DATA_WIDTH'(1);
         OP_CLEAR: new_c = '0;
         default:  new_c = old_c;
      endcase
   end

   always_comb begin
      wrap_c = wr_hit_c &&
               (((wr_op == OP_INC) && (old_c == {DATA_WIDTH{1'b1}})) ||
                ((wr_op == OP_DEC) && (old_c == '0)));
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
         regs_nxt_c[i] = (wr_hit_c && (wr_sel == SEL_WIDTH'(i))) ? new_c : regs[i];
      end
   end

   // Read source: post-write contents when bypassing, current contents otherwise.
   always_comb begin
`ifdef REGSET_BYPASS_EN
      rd_view_c = regs_nxt_c;
`else
      rd_view_c = regs;
`endif
   end

   always_comb begin
      rd_data1_c = '0;
      rd_data2_c = '0;
      for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
         if (rd_sel1 == SEL_WIDTH'(i)) rd_data1_c = rd_view_c[i];
         if (rd_sel2 == SEL_WIDTH'(i)) rd_data2_c = rd_view_c[i];
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         regs      <= '{default: '0};
         reg_out_1 <= '0;
         reg_out_2 <= '0;
         wr_wrap   <= 1'b0;
      end else begin
         regs    <= regs_nxt_c;
         wr_wrap <= wrap_c;
         if (rd_en1) reg_out_1 <= rd_data1_c;
         if (rd_en2) reg_out_2 <= rd_data2_c;
      end
   end

endmodule

// File: tb/tb_registerset_param.sv
// Scoreboard bench for registerset_param: default, 3-register and 16-bit/8-register instances.
module tb_registerset_param;

   logic        clk = 1'b0;
   logic [2:0]  res_v, wen_v, re1_v, re2_v;
   logic [1:0]  op;
   logic [2:0]  wsel, s1, s2;
   logic [15:0] din;

   logic [7:0]  a_o1, a_o2, b_o1, b_o2;
   logic [15:0] c_o1, c_o2;
   logic        a_w, b_w, c_w;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          which;
      logic [15:0] o1;
      logic [15:0] o2;
      logic        w;
      string       name;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   registerset_param #(.DATA_WIDTH(8), .SEL_WIDTH(2), .NUM_REGISTERS(4)) dut_a (
      .clk(clk), .res(res_v[0]), .wr_en(wen_v[0]), .wr_op(op), .wr_sel(wsel[1:0]),
      .reg_in(din[7:0]), .rd_en1(re1_v[0]), .rd_en2(re2_v[0]), .rd_sel1(s1[1:0]),
      .rd_sel2(s2[1:0]), .reg_out_1(a_o1), .reg_out_2(a_o2), .wr_wrap(a_w));

   registerset_param #(.DATA_WIDTH(8), .SEL_WIDTH(2), .NUM_REGISTERS(3)) dut_b (
      .clk(clk), .res(res_v[1]), .wr_en(wen_v[1]), .wr_op(op), .wr_sel(wsel[1:0]),
      .reg_in(din[7:0]), .rd_en1(re1_v[1]), .rd_en2(re2_v[1]), .rd_sel1(s1[1:0]),
      .rd_sel2(s2[1:0]), .reg_out_1(b_o1), .reg_out_2(b_o2), .wr_wrap(b_w));

   registerset_param #(.DATA_WIDTH(16), .SEL_WIDTH(3), .NUM_REGISTERS(8)) dut_c (
      .clk(clk), .res(res_v[2]), .wr_en(wen_v[2]), .wr_op(op), .wr_sel(wsel),
      .reg_in(din), .rd_en1(re1_v[2]), .rd_en2(re2_v[2]), .rd_sel1(s1),
      .rd_sel2(s2), .reg_out_1(c_o1), .reg_out_2(c_o2), .wr_wrap(c_w));

   // One cycle on one instance; expectation is what its outputs show after this edge.
   task automatic cyc(input int which, input string name, input bit rs,
                      input bit we, input logic [1:0] o, input int ws, input int d,
                      input bit r1, input int rs1, input bit r2, input int rs2,
                      input int e1, input int e2, input bit ew);
      exp_t e;
      @(negedge clk);
      res_v = '0; wen_v = '0; re1_v = '0; re2_v = '0;
      res_v[which] = rs;
      wen_v[which] = we;
      re1_v[which] = r1;
      re2_v[which] = r2;
      op   = o;
      wsel = 3'(ws);
      din  = 16'(d);
      s1   = 3'(rs1);
      s2   = 3'(rs2);
      e.which = which;
      e.o1    = 16'(e1);
      e.o2    = 16'(e2);
      e.w     = ew;
      e.name  = name;
      q.push_back(e);
   endtask

   // Monitor: outputs are presented every cycle, so one expectation is consumed per edge.
   always @(posedge clk) begin
      exp_t e;
      logic [15:0] g1, g2;
      logic gw;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         case (e.which)
            0:       begin g1 = {8'h00, a_o1}; g2 = {8'h00, a_o2}; gw = a_w; end
            1:       begin g1 = {8'h00, b_o1}; g2 = {8'h00, b_o2}; gw = b_w; end
            default: begin g1 = c_o1; g2 = c_o2; gw = c_w; end
         endcase
         checks++;
         if (g1 !== e.o1) begin
            errors++;
            $display("FAIL %s reg_out_1 got %h want %h", e.name, g1, e.o1);
         end
         checks++;
         if (g2 !== e.o2) begin
            errors++;
            $display("FAIL %s reg_out_2 got %h want %h", e.name, g2, e.o2);
         end
         checks++;
         if (gw !== e.w) begin
            errors++;
            $display("FAIL %s wr_wrap got %b want %b", e.name, gw, e.w);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   localparam logic [1:0] LD = 2'b00, INC = 2'b01, DEC = 2'b10, CLR = 2'b11;

   initial begin
      logic [15:0] vals [8];
      int rdw;
      vals = '{16'h0A00, 16'h0B01, 16'h0C02, 16'h0D03, 16'h0E04, 16'h0F05, 16'h1006, 16'hFFFF};
`ifdef REGSET_BYPASS_EN
      rdw = 99;
`else
      rdw = 15;
`endif
      res_v = '0; wen_v = '0; re1_v = '0; re2_v = '0;
      op = LD; wsel = '0; din = '0; s1 = '0; s2 = '0;

      // Default instance: reset, load, wrap, hold, read-during-write, reset mid-op
      cyc(0, "a_reset",     1, 0, LD,  0,   0, 0, 0, 0, 0,   0,   0,   0);
      cyc(0, "a_ld_r3",     0, 1, LD,  3, 255, 0, 0, 0, 0,   0,   0,   0);
      cyc(0, "a_ld_r2",     0, 1, LD,  2,  15, 0, 0, 0, 0,   0,   0,   0);
      cyc(0, "a_ld_r0_rd",  0, 1, LD,  0, 128, 1, 3, 1, 2, 255,  15,   0);
      cyc(0, "a_ld_r1",     0, 1, LD,  1, 255, 0, 0, 0, 0, 255,  15,   0);
      cyc(0, "a_inc_wrap",  0, 1, INC, 1,  33, 0, 0, 0, 0, 255,  15,   1);
      cyc(0, "a_rd_r1_0",   0, 0, LD,  0,   0, 1, 1, 0, 0,   0,  15,   0);
      cyc(0, "a_dec_wrap",  0, 1, DEC, 1,   0, 0, 0, 0, 0,   0,  15,   1);
      cyc(0, "a_rd_r1_ff",  0, 0, LD,  0,   0, 1, 1, 0, 0, 255,  15,   0);
      cyc(0, "a_clr_r1",    0, 1, CLR, 1,  77, 0, 0, 0, 0, 255,  15,   0);
      cyc(0, "a_rd_r1_clr", 0, 0, LD,  0,   0, 1, 1, 0, 0,   0,  15,   0);
      cyc(0, "a_rd_r0",     0, 0, LD,  0,   0, 1, 0, 0, 0, 128,  15,   0);
      cyc(0, "a_hold_ld7",  0, 1, LD,  0,   7, 0, 0, 0, 0, 128,  15,   0);
      cyc(0, "a_hold_idle", 0, 0, LD,  0,   0, 0, 0, 0, 0, 128,  15,   0);
      cyc(0, "a_rd2_r0",    0, 0, LD,  0,   0, 0, 0, 1, 0, 128,   7,   0);
      cyc(0, "a_inc_r0",    0, 1, INC, 0, 200, 0, 0, 0, 0, 128,   7,   0);
      cyc(0, "a_dec_r3",    0, 1, DEC, 3,   0, 0, 0, 0, 0, 128,   7,   0);
      cyc(0, "a_rd_r0_r3",  0, 0, LD,  0,   0, 1, 0, 1, 3,   8, 254,   0);
      cyc(0, "a_rdw",       0, 1, LD,  2,  99, 1, 2, 1, 2, rdw, rdw,   0);
      cyc(0, "a_rd_after",  0, 0, LD,  0,   0, 1, 2, 1, 2,  99,  99,   0);
      cyc(0, "a_wen0_inc",  0, 0, INC, 2,   0, 0, 0, 0, 0,  99,  99,   0);
      cyc(0, "a_rd_r2",     0, 0, LD,  0,   0, 1, 2, 0, 0,  99,  99,   0);
      cyc(0, "a_ld_r3_ff",  0, 1, LD,  3, 255, 0, 0, 0, 0,  99,  99,   0);
      cyc(0, "a_res_mid",   1, 1, INC, 3,   0, 1, 3, 0, 0,   0,   0,   0);
      cyc(0, "a_post_res",  0, 1, LD,  0,   5, 1, 3, 1, 2,   0,   0,   0);
      cyc(0, "a_rd_r0_5",   0, 0, LD,  0,   0, 1, 0, 0, 0,   5,   0,   0);

      // Three-register instance: out-of-range read and write
      cyc(1, "b_reset",     1, 0, LD,  0,   0, 0, 0, 0, 0,   0,   0,   0);
      cyc(1, "b_ld_r2",     0, 1, LD,  2,  42, 0, 0, 0, 0,   0,   0,   0);
      cyc(1, "b_rd_r2",     0, 0, LD,  0,   0, 1, 2, 1, 2,  42,  42,   0);
      cyc(1, "b_rd_sel3",   0, 0, LD,  0,   0, 1, 3, 0, 0,   0,  42,   0);
      cyc(1, "b_dec_sel3",  0, 1, DEC, 3,   0, 0, 0, 0, 0,   0,  42,   0);
      cyc(1, "b_ld_sel3",   0, 1, LD,  3,  77, 0, 0, 0, 0,   0,  42,   0);
      cyc(1, "b_inc_sel3",  0, 1, INC, 3,   0, 1, 3, 1, 2,   0,  42,   0);
      cyc(1, "b_rd_r0_r1",  0, 0, LD,  0,   0, 1, 0, 1, 1,   0,   0,   0);
      cyc(1, "b_rd_r2_chk", 0, 0, LD,  0,   0, 0, 0, 1, 2,   0,  42,   0);

      // 16-bit, eight-register instance
      cyc(2, "c_reset",     1, 0, LD,  0,   0, 0, 0, 0, 0,   0,   0,   0);
      for (int i = 0; i < 8; i++)
         cyc(2, "c_load", 0, 1, LD, i, int'(vals[i]), 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc(2, "c_read", 0, 0, LD, 0, 0, 1, i, 1, 7 - i,
             int'(vals[i]), int'(vals[7 - i]), 0);
      cyc(2, "c_inc_wrap",  0, 1, INC, 7,   0, 0, 0, 0, 0,
          int'(vals[7]), int'(vals[0]), 1);
      cyc(2, "c_rd_r7",     0, 0, LD,  0,   0, 1, 7, 1, 6,
          0, int'(vals[6]), 0);

      @(negedge clk);
      res_v = '0; wen_v = '0; re1_v = '0; re2_v = '0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
